rr_mux_arbiter8: RTL and testbench
==================================

// Module: rr_mux_arbiter8
// PURPOSE
//  Round-robin arbiter that shares one 8:1 bit-mux between 8 requesters.
//  Owns the mux select: grants one requester at a time, holds the grant while
//  the owner keeps req high, and pre-empts after MAX_HOLD cycles if others wait.
//  Sits in front of the eighttoonemux datapath; out = in[sel] while granted.
// PARAMETERS
//  N         8   number of requesters (fixed 8; sel is 3 bits)
//  MAX_HOLD  4   max consecutive grant cycles when others pending; 0 = unlimited
//  HOLD_W    3   width of hold counter; must satisfy 2**HOLD_W >= MAX_HOLD
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  req        in   8  level requests, bit i = requester i
//  in         in   8  mux data inputs, bit i belongs to requester i
//  gnt        out  8  one-hot grant, registered
//  gnt_valid  out  1  high when a grant is active, registered
//  sel        out  3  encoded index of owner, registered; drives mux select
//  out        out  1  in[sel] when gnt_valid, else 0 (combinational from sel)
// BEHAVIOUR
//  Reset (async, any time): gnt=0, gnt_valid=0, sel=0, out=0, state=IDLE,
//   ptr=7 (first arbitration favours requester 0), hold_cnt=0.
//  Arbitration: search starts at ptr+1 mod 8, wraps 7->0; first req bit set wins.
//  States: IDLE, GRANT.
//   IDLE : req==0 -> stay. req!=0 -> GRANT to winner; gnt/sel/gnt_valid valid
//          next edge (latency 1 cycle from req to gnt). ptr<=winner, hold_cnt<=0.
//   GRANT: owner=sel.
//    req[owner]=0 and other req pending -> switch to next winner (searched from
//     owner+1) at next edge, no idle cycle; hold_cnt<=0.
//    req[owner]=0 and no other req -> IDLE next edge; gnt, gnt_valid -> 0;
//     sel holds last value.
//    req[owner]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, other req pending ->
//     pre-empt: grant next winner (excluding owner) next edge; hold_cnt<=0.
//    req[owner]=1, otherwise -> keep grant; hold_cnt increments, saturates at
//     MAX_HOLD-1 (no pre-empt while alone; pre-empt as soon as another arrives).
//  Owner dropping req on the same edge as pre-empt point: release rule wins.
//  New requests arriving mid-grant never disturb the current owner until release
//   or hold expiry. gnt is always one-hot or zero; gnt==(1<<sel) when gnt_valid.
//  out is combinational from registered sel and live in; zero when !gnt_valid.
// STRUCTURE
//  Shared package/include: N=8, SEL_W=3, state encodings ST_IDLE=1'b0,
//   ST_GRANT=1'b1.
//  Sub-module: rr_pick8 -- combinational rotate-priority picker
//   (req[7:0], start[2:0], mask_idx[2:0], mask_en) -> (found, idx[2:0]).
//  Output mux: instance of existing eighttoonemux (in, sel, raw), gated with
//   gnt_valid.
// TESTING
//  1 rst pulse mid-run with req=8'hFF -> same cycle gnt=0, gnt_valid=0, sel=0,
//    out=0; after release with req=8'hFF, first gnt=8'h01.
//  2 from reset, req=8'h08 at cycle t -> t+1 gnt=8'h08, sel=3, gnt_valid=1;
//    toggle in[3] -> out tracks; toggle in[2] -> out unchanged.
//  3 req=8'hFF held, MAX_HOLD=4 -> owner order 0,1,...,7,0, each exactly
//    4 cycles, no gap cycles.
//  4 req=8'h05, owner 0 drops req[0] at cycle t -> t+1 gnt=8'h04, sel=2;
//    then req=0 -> next cycle gnt_valid=0, out=0, sel stays 2.
//  5 wrap: owner 7 with req=8'h81, hold expires -> gnt=8'h01 next edge;
//    req=8'h80 alone -> owner 7 holds indefinitely, hold_cnt saturates.
//  6 MAX_HOLD=0, req=8'h03 -> owner 0 kept until req[0]=0, then gnt=8'h02
//    next edge.

Source files
------------

// File: rtl/rr_mux_arbiter8_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter8_pkg
// Shared constants and types for the round-robin 8:1 mux arbiter.
//   N          number of requesters (fixed at 8)
//   SEL_W      width of the encoded select (3 bits)
//   state_t    arbiter FSM states (ST_IDLE, ST_GRANT)
//   sel_to_onehot  helper converting an encoded index to a one-hot grant
// -----------------------------------------------------------------------------
package rr_mux_arbiter8_pkg;

  localparam int N     = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/eighttoonemux.sv
// -----------------------------------------------------------------------------
// eighttoonemux
// Plain 8:1 bit multiplexer: out = in[sel].
//   in   in   8  data inputs
//   sel  in   3  select index
//   out  out  1  selected bit
// -----------------------------------------------------------------------------
module eighttoonemux (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational rotate-priority picker. Scans i_req starting at index i_start,
// wrapping 7->0, and returns the first set bit. When i_mask_en is high the
// bit at i_mask_idx is ignored (used to exclude the current owner).
//   i_req       in   8  request vector
//   i_start     in   3  first index examined
//   i_mask_idx  in   3  index to exclude when i_mask_en
//   i_mask_en   in   1  enable exclusion
//   o_found     out  1  at least one eligible request
//   o_idx       out  3  index of the winner (don't-care when !o_found)
// -----------------------------------------------------------------------------
module rr_pick8
  import rr_mux_arbiter8_pkg::*;
(
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_start,
  input  logic [SEL_W-1:0] i_mask_idx,
  input  logic             i_mask_en,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_cand;

  // NOTE: every output of this always_comb gets a default before the loop,
  // otherwise paths that never hit a request would infer latches.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    w_cand  = '0;
    // Walk from the farthest offset back to the nearest so that the nearest
    // eligible request is the last (and therefore winning) assignment.
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = i_start + SEL_W'(k);
      if (i_req[w_cand] && !(i_mask_en && (w_cand == i_mask_idx))) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter8
// Round-robin arbiter owning the select of a shared 8:1 bit mux. One requester
// is granted at a time; the grant is held while the owner keeps req high, and
// is pre-empted after MAX_HOLD cycles if anyone else is waiting (MAX_HOLD = 0
// disables pre-emption).
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   req        in   8  level requests
//   in         in   8  mux data inputs, bit i belongs to requester i
//   gnt        out  8  one-hot grant (registered)
//   gnt_valid  out  1  a grant is active (registered)
//   sel        out  3  encoded owner index (registered), drives the mux
//   out        out  1  in[sel] while gnt_valid, else 0
// -----------------------------------------------------------------------------
module rr_mux_arbiter8
  import rr_mux_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     in,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] sel,
  output logic             out
);

  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
  // With pre-emption disabled the counter simply saturates at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic [N-1:0]      r_gnt;
  logic              r_gnt_valid;
  logic [SEL_W-1:0]  r_sel;

  logic              w_in_grant;
  logic              w_owner_req;
  logic              w_hold_last;
  logic [SEL_W-1:0]  w_start;
  logic              w_found;
  logic [SEL_W-1:0]  w_idx;
  logic              w_take;
  logic              w_release;
  logic              w_raw;

  assign w_in_grant  = (r_state == ST_GRANT);
  assign w_owner_req = req[r_sel];
  assign w_hold_last = (r_hold == HOLD_LAST);

  // While idle the search resumes after the last winner; while granted it
  // starts after the owner and the owner itself is masked out, so w_found
  // means "someone else is waiting".
  assign w_start = w_in_grant ? (r_sel + SEL_W'(1)) : (r_ptr + SEL_W'(1));

  rr_pick8 u_pick (
    .i_req      (req),
    .i_start    (w_start),
    .i_mask_idx (r_sel),
    .i_mask_en  (w_in_grant),
    .o_found    (w_found),
    .o_idx      (w_idx)
  );

  // Hand the grant to w_idx: new grant from idle, owner released with others
  // waiting, or hold expired with others waiting. Release takes priority over
  // pre-emption simply because both lead to the same hand-over.
  assign w_take = w_found &&
                  (!w_in_grant || !w_owner_req || (PREEMPT_EN && w_hold_last));
  assign w_release = w_in_grant && !w_owner_req && !w_found;

  // NOTE: all state registers update with non-blocking assignments so every
  // decision in this block sees the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= SEL_W'(N - 1);
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_sel       <= '0;
    end else if (w_take) begin
      r_state     <= ST_GRANT;
      r_ptr       <= w_idx;
      r_hold      <= '0;
      r_gnt       <= sel_to_onehot(w_idx);
      r_gnt_valid <= 1'b1;
      r_sel       <= w_idx;
    end else if (w_release) begin
      // sel deliberately keeps the last owner.
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
    end else if (w_in_grant && !w_hold_last) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign sel       = r_sel;

  eighttoonemux u_mux (
    .in  (in),
    .sel (r_sel),
    .out (w_raw)
  );

  assign out = w_raw & r_gnt_valid;

endmodule

// File: tb/tb_rr_mux_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter8
// Scoreboard bench: the stimulus process applies inputs on the falling edge and
// queues the outputs expected just after the following rising edge; the
// monitor pops one entry per rising edge and compares. dut0 uses MAX_HOLD=4,
// dut1 uses MAX_HOLD=0; both see the same inputs, each entry names its target.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;

  logic [7:0] g0, g1;
  logic       v0, v1;
  logic [2:0] s0, s1;
  logic       o0, o1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    bit         which;
    bit         chk;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       v;
    logic       o;
  } exp_t;

  exp_t q[$];
  int   step_id = 0;

  rr_mux_arbiter8 #(.MAX_HOLD(4), .HOLD_W(3)) dut0 (
    .clk(clk), .rst(rst), .req(req), .in(din),
    .gnt(g0), .gnt_valid(v0), .sel(s0), .out(o0)
  );

  rr_mux_arbiter8 #(.MAX_HOLD(0), .HOLD_W(3)) dut1 (
    .clk(clk), .rst(rst), .req(req), .in(din),
    .gnt(g1), .gnt_valid(v1), .sel(s1), .out(o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit which, input bit chk, input logic [7:0] eg,
                          input logic [2:0] es, input logic ev, input logic eo);
    exp_t e;
    step_id++;
    e.id = step_id; e.which = which; e.chk = chk;
    e.gnt = eg; e.sel = es; e.v = ev; e.o = eo;
    q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [7:0] rq, input logic [7:0] d,
                      input bit which, input bit chk, input logic [7:0] eg,
                      input logic [2:0] es, input logic ev, input logic eo);
    @(negedge clk);
    rst = r;
    req = rq;
    din = d;
    push_exp(which, chk, eg, es, ev, eo);
  endtask

  // Monitor: one queue entry per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        if (e.which == 1'b0) begin
          check($sformatf("s%0d d0.gnt", e.id), g0, e.gnt);
          check($sformatf("s%0d d0.sel", e.id), 8'(s0), 8'(e.sel));
          check($sformatf("s%0d d0.gnt_valid", e.id), 8'(v0), 8'(e.v));
          check($sformatf("s%0d d0.out", e.id), 8'(o0), 8'(e.o));
        end else begin
          check($sformatf("s%0d d1.gnt", e.id), g1, e.gnt);
          check($sformatf("s%0d d1.sel", e.id), 8'(s1), 8'(e.sel));
          check($sformatf("s%0d d1.gnt_valid", e.id), 8'(v1), 8'(e.v));
          check($sformatf("s%0d d1.out", e.id), 8'(o1), 8'(e.o));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] oh;
    pat = 8'hA5;  // bits: 0=1 1=0 2=1 3=0 4=0 5=1 6=0 7=1

    rst = 1'b1;
    req = 8'h00;
    din = 8'h00;
    #1;
    check("reset gnt", g0, 8'h00);
    check("reset gnt_valid", 8'(v0), 8'h00);
    check("reset sel", 8'(s0), 8'h00);
    check("reset out", 8'(o0), 8'h00);

    // Single request from reset: owner 3, out follows in[3] only.
    step(0, 8'h08, 8'h00, 0, 1, 8'h08, 3'd3, 1'b1, 1'b0);
    step(0, 8'h08, 8'h08, 0, 1, 8'h08, 3'd3, 1'b1, 1'b1);
    step(0, 8'h08, 8'h04, 0, 1, 8'h08, 3'd3, 1'b1, 1'b0);
    step(0, 8'h08, 8'h0C, 0, 1, 8'h08, 3'd3, 1'b1, 1'b1);
    step(0, 8'h00, 8'h00, 0, 1, 8'h00, 3'd3, 1'b0, 1'b0);

    // Idle with ptr=3: req=05 -> owner 0; drop req[0] -> owner 2; then idle.
    step(0, 8'h05, 8'h00, 0, 1, 8'h01, 3'd0, 1'b1, 1'b0);
    step(0, 8'h05, 8'h01, 0, 1, 8'h01, 3'd0, 1'b1, 1'b1);
    step(0, 8'h04, 8'hFF, 0, 1, 8'h04, 3'd2, 1'b1, 1'b1);
    step(0, 8'h00, 8'hFF, 0, 1, 8'h00, 3'd2, 1'b0, 1'b0);

    // Mid-run asynchronous reset with all requesters active (ptr=2 -> owner 3).
    step(0, 8'hFF, pat, 0, 1, 8'h08, 3'd3, 1'b1, 1'b0);
    step(0, 8'hFF, pat, 0, 1, 8'h08, 3'd3, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    push_exp(0, 1, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    check("async rst gnt", g0, 8'h00);
    check("async rst gnt_valid", 8'(v0), 8'h00);
    check("async rst sel", 8'(s0), 8'h00);
    check("async rst out", 8'(o0), 8'h00);

    // Release with req=FF: owners 0..7,0 each exactly 4 cycles, no gaps.
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < 4; c++) begin
        oh = 8'h01 << (i % 8);
        step(0, 8'hFF, pat, 0, 1, oh, 3'(i % 8), 1'b1, pat[i % 8]);
      end
    end

    // Owner 0 expired, req=81 -> owner 7 for 4 cycles, then wraps to 0.
    for (int c = 0; c < 4; c++)
      step(0, 8'h81, pat, 0, 1, 8'h80, 3'd7, 1'b1, 1'b1);
    step(0, 8'h81, pat, 0, 1, 8'h01, 3'd0, 1'b1, 1'b1);

    // Owner 7 alone for 10 cycles; hold counter must saturate, so a new
    // request pre-empts on the very next edge.
    for (int c = 0; c < 10; c++)
      step(0, 8'h80, pat, 0, 1, 8'h80, 3'd7, 1'b1, 1'b1);
    step(0, 8'h82, pat, 0, 1, 8'h02, 3'd1, 1'b1, 1'b0);

    // MAX_HOLD=0 instance: owner 0 never pre-empted, released to 1 on drop.
    step(1, 8'h00, pat, 1, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++)
      step(0, 8'h03, pat, 1, 1, 8'h01, 3'd0, 1'b1, 1'b1);
    step(0, 8'h02, pat, 1, 1, 8'h02, 3'd1, 1'b1, 1'b0);
    step(0, 8'h00, pat, 1, 1, 8'h00, 3'd1, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++)
      @(posedge clk);
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
